// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for register-format ALU instructions.
// Drives DataPath bus/load enables from a Moore FSM plus the IR register fields.
module control_sequencer #(
    parameter logic [4:0] OP_MUL        = 5'h0F,
    parameter logic [4:0] OP_DIV        = 5'h10,
    parameter logic [4:0] OP_MAX_SIMPLE = 5'h0E
) (
    input  logic        i_clock,
    input  logic        i_clear,
    input  logic        i_run,
    input  logic        i_mem_ready,
    input  logic [31:0] i_ir,
    output logic        o_pcout,
    output logic        o_zhighout,
    output logic        o_zlowout,
    output logic        o_mdrout,
    output logic        o_marin,
    output logic        o_pcin,
    output logic        o_mdrin,
    output logic        o_irin,
    output logic        o_yin,
    output logic        o_incpc,
    output logic        o_read,
    output logic        o_zlowin,
    output logic        o_zhighin,
    output logic        o_hiin,
    output logic        o_loin,
    output logic [4:0]  o_alu_op,
    output logic [15:0] o_rout,
    output logic [15:0] o_rin,
    output logic        o_done,
    output logic        o_illegal,
    output logic [15:0] o_instr_count
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6
    } state_e;

    state_e      r_state;
    state_e      w_next_state;
    state_e      w_after_instr;
    logic [15:0] r_instr_count;
    logic [15:0] w_count_next;

    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_hilo;
    logic        w_legal;
    logic        w_unused_ir;

    assign w_opcode    = i_ir[31:27];
    assign w_ra        = i_ir[26:23];
    assign w_rb        = i_ir[22:19];
    assign w_rc        = i_ir[18:15];
    assign w_unused_ir = ^i_ir[14:0];

    assign w_hilo        = (w_opcode == OP_MUL) || (w_opcode == OP_DIV);
    assign w_legal       = (w_opcode <= OP_MAX_SIMPLE) || w_hilo;
    // Run is only sampled when an instruction ends (or aborts as illegal).
    assign w_after_instr = i_run ? StT0 : StIdle;

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state       <= StIdle;
            r_instr_count <= 16'h0000;
        end else begin
            r_state       <= w_next_state;
            r_instr_count <= w_count_next;
        end
    end

    assign w_count_next  = o_done ? r_instr_count + 16'h0001 : r_instr_count;
    assign o_instr_count = r_instr_count;

    always_comb begin
        w_next_state = r_state;
        o_pcout      = 1'b0;
        o_zhighout   = 1'b0;
        o_zlowout    = 1'b0;
        o_mdrout     = 1'b0;
        o_marin      = 1'b0;
        o_pcin       = 1'b0;
        o_mdrin      = 1'b0;
        o_irin       = 1'b0;
        o_yin        = 1'b0;
        o_incpc      = 1'b0;
        o_read       = 1'b0;
        o_zlowin     = 1'b0;
        o_zhighin    = 1'b0;
        o_hiin       = 1'b0;
        o_loin       = 1'b0;
        o_alu_op     = 5'h00;
        o_rout       = 16'h0000;
        o_rin        = 16'h0000;
        o_done       = 1'b0;
        o_illegal    = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_run) w_next_state = StT0;
            end
            StT0: begin
                o_pcout      = 1'b1;
                o_marin      = 1'b1;
                o_incpc      = 1'b1;
                o_zlowin     = 1'b1;
                w_next_state = StT1;
            end
            StT1: begin
                // PC reload from Z repeats while waiting; harmless since Z is stable.
                o_zlowout = 1'b1;
                o_pcin    = 1'b1;
                o_read    = 1'b1;
                o_mdrin   = 1'b1;
                if (i_mem_ready) w_next_state = StT2;
            end
            StT2: begin
                o_mdrout     = 1'b1;
                o_irin       = 1'b1;
                w_next_state = StT3;
            end
            StT3: begin
                if (w_legal) begin
                    o_rout       = 16'h0001 << w_rc;
                    o_yin        = 1'b1;
                    w_next_state = StT4;
                end else begin
                    o_illegal    = 1'b1;
                    w_next_state = w_after_instr;
                end
            end
            StT4: begin
                o_rout       = 16'h0001 << w_rb;
                o_alu_op     = w_opcode;
                o_zlowin     = 1'b1;
                o_zhighin    = w_hilo;
                w_next_state = StT5;
            end
            StT5: begin
                o_zlowout = 1'b1;
                if (w_hilo) begin
                    o_loin       = 1'b1;
                    w_next_state = StT6;
                end else begin
                    o_rin        = 16'h0001 << w_ra;
                    o_done       = 1'b1;
                    w_next_state = w_after_instr;
                end
            end
            StT6: begin
                o_zhighout   = 1'b1;
                o_hiin       = 1'b1;
                o_done       = 1'b1;
                w_next_state = w_after_instr;
            end
            default: w_next_state = StIdle;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer: per-cycle comparison against a phase-indexed
// behavioural model, plus directed instruction sequences with literal expectations.
module tb_control_sequencer;

    typedef struct packed {
        logic pcout, zhighout, zlowout, mdrout, marin, pcin, mdrin, irin, yin;
        logic incpc, read, zlowin, zhighin, hiin, loin, done, illegal;
        logic [4:0]  alu_op;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [15:0] cnt;
    } outs_t;

    logic        clk = 1'b0;
    logic        i_clear, i_run, i_mem;
    logic [31:0] i_ir;
    logic        o_pcout, o_zhighout, o_zlowout, o_mdrout, o_marin, o_pcin, o_mdrin;
    logic        o_irin, o_yin, o_incpc, o_read, o_zlowin, o_zhighin, o_hiin, o_loin;
    logic        o_done, o_illegal;
    logic [4:0]  o_alu_op;
    logic [15:0] o_rout, o_rin, o_instr_count;
    outs_t       act;

    int          n_cmp = 0;
    int          n_err = 0;

    // Model: phase -1 is idle, 0..6 index the T-states of the current instruction.
    int          m_ph;
    logic [31:0] m_ir;
    logic [15:0] m_cnt;
    logic [31:0] next_ir;

    always #5 clk = ~clk;

    control_sequencer dut (
        .i_clock      (clk),
        .i_clear      (i_clear),
        .i_run        (i_run),
        .i_mem_ready  (i_mem),
        .i_ir         (i_ir),
        .o_pcout      (o_pcout),
        .o_zhighout   (o_zhighout),
        .o_zlowout    (o_zlowout),
        .o_mdrout     (o_mdrout),
        .o_marin      (o_marin),
        .o_pcin       (o_pcin),
        .o_mdrin      (o_mdrin),
        .o_irin       (o_irin),
        .o_yin        (o_yin),
        .o_incpc      (o_incpc),
        .o_read       (o_read),
        .o_zlowin     (o_zlowin),
        .o_zhighin    (o_zhighin),
        .o_hiin       (o_hiin),
        .o_loin       (o_loin),
        .o_alu_op     (o_alu_op),
        .o_rout       (o_rout),
        .o_rin        (o_rin),
        .o_done       (o_done),
        .o_illegal    (o_illegal),
        .o_instr_count(o_instr_count)
    );

    assign act = {o_pcout, o_zhighout, o_zlowout, o_mdrout, o_marin, o_pcin, o_mdrin, o_irin,
                  o_yin, o_incpc, o_read, o_zlowin, o_zhighin, o_hiin, o_loin, o_done,
                  o_illegal, o_alu_op, o_rout, o_rin, o_instr_count};

    function automatic outs_t expect_outs(input int ph, input logic [31:0] ir,
                                          input logic [15:0] cnt);
        outs_t e;
        int    op;
        bit    hilo;
        e     = '0;
        e.cnt = cnt;
        op    = int'(ir[31:27]);
        hilo  = (op == 15) || (op == 16);
        case (ph)
            0: begin e.pcout = 1; e.marin = 1; e.incpc = 1; e.zlowin = 1; end
            1: begin e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; end
            2: begin e.mdrout = 1; e.irin = 1; end
            3: if (op <= 16) begin
                   e.rout = 16'(1 << ir[18:15]);
                   e.yin  = 1;
               end else e.illegal = 1;
            4: begin
                   e.rout    = 16'(1 << ir[22:19]);
                   e.alu_op  = ir[31:27];
                   e.zlowin  = 1;
                   e.zhighin = hilo;
               end
            5: begin
                   e.zlowout = 1;
                   if (hilo) e.loin = 1;
                   else begin e.rin = 16'(1 << ir[26:23]); e.done = 1; end
               end
            6: begin e.zhighout = 1; e.hiin = 1; e.done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_edge();
        int op;
        op = int'(m_ir[31:27]);
        if (i_clear) begin
            m_ph  = -1;
            m_cnt = 16'h0000;
            return;
        end
        case (m_ph)
            -1: if (i_run) m_ph = 0;
            1: if (i_mem) m_ph = 2;
            2: begin m_ph = 3; m_ir = next_ir; end
            3: m_ph = (op > 16) ? (i_run ? 0 : -1) : 4;
            5: if (op == 15 || op == 16) m_ph = 6;
               else begin m_cnt = m_cnt + 16'h1; m_ph = i_run ? 0 : -1; end
            6: begin m_cnt = m_cnt + 16'h1; m_ph = i_run ? 0 : -1; end
            default: m_ph = m_ph + 1;
        endcase
    endtask

    task automatic check_model();
        outs_t e;
        int    drivers;
        int    want;
        e = expect_outs(m_ph, m_ir, m_cnt);
        n_cmp++;
        if (act !== e) begin
            n_err++;
            $display("FAIL model ph=%0d ir=%h: got %h required %h", m_ph, m_ir, act, e);
        end
        drivers = int'(o_pcout) + int'(o_zhighout) + int'(o_zlowout) + int'(o_mdrout)
                  + $countones(o_rout);
        want = (m_ph < 0 || (m_ph == 3 && m_ir[31:27] > 5'd16)) ? 0 : 1;
        n_cmp++;
        if (drivers != want) begin
            n_err++;
            $display("FAIL bus_drivers ph=%0d: got %0d required %0d", m_ph, drivers, want);
        end
    endtask

    task automatic lit(input string name, input logic [69:0] got, input logic [69:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Apply inputs, take one clock edge, then compare at the following falling edge.
    task automatic step(input logic run, input logic mem);
        i_run = run;
        i_mem = mem;
        @(posedge clk);
        model_edge();
        #1 i_ir = m_ir;
        @(negedge clk);
        check_model();
    endtask

    initial begin
        i_clear = 1'b1;
        i_run   = 1'b0;
        i_mem   = 1'b0;
        i_ir    = 32'h0;
        m_ph    = -1;
        m_ir    = 32'h0;
        m_cnt   = 16'h0;
        next_ir = 32'h0;
        repeat (2) @(negedge clk);
        check_model();
        lit("reset_outs", act, 70'h0);
        i_clear = 1'b0;
        step(0, 0);

        // Shift: opcode 0x0B, ra=4, rb=3, rc=7
        next_ir = 32'h5A1B8000;
        repeat (4) step(1, 1);
        lit("shift_t3_rout", o_rout, 16'h0080);
        lit("shift_t3_yin", o_yin, 1);
        step(1, 1);
        lit("shift_t4_rout", o_rout, 16'h0008);
        lit("shift_t4_alu", o_alu_op, 5'b01011);
        lit("shift_t4_zlowin", o_zlowin, 1);
        step(1, 1);
        lit("shift_t5_zlowout", o_zlowout, 1);
        lit("shift_t5_rin", o_rin, 16'h0010);
        lit("shift_t5_done", o_done, 1);
        step(0, 1);
        lit("shift_count", o_instr_count, 16'd1);

        // Multiply: opcode 0x0F, two-result writeback
        next_ir = 32'h781B8000;
        repeat (5) step(1, 1);
        lit("mul_t4_z", {o_zlowin, o_zhighin}, 2'b11);
        step(1, 1);
        lit("mul_t5", {o_zlowout, o_loin, o_done}, 3'b110);
        lit("mul_t5_rin", o_rin, 16'h0000);
        step(1, 1);
        lit("mul_t6", {o_zhighout, o_hiin, o_done}, 3'b111);
        step(0, 1);
        lit("mul_count", o_instr_count, 16'd2);

        // Memory wait: four cycles in T1 before IR load
        next_ir = 32'h5A1B8000;
        step(1, 1);
        step(1, 0);
        for (int i = 0; i < 4; i++) begin
            lit("memwait_t1", {o_read, o_mdrin, o_pcin}, 3'b111);
            if (i < 3) step(1, 0);
        end
        step(1, 1);
        lit("memwait_t2", {o_mdrout, o_irin, o_read}, 3'b110);
        repeat (3) step(1, 1);
        step(0, 1);
        lit("memwait_count", o_instr_count, 16'd3);

        // Illegal opcode 0x1F
        next_ir = 32'hF8000000;
        repeat (4) step(1, 1);
        lit("illegal_t3", {o_illegal, o_rout, o_rin}, {1'b1, 32'h0});
        next_ir = 32'h5A1B8000;
        step(1, 1);
        lit("illegal_back_t0", o_pcout, 1);
        lit("illegal_count", o_instr_count, 16'd3);

        // Clear asserted in T4
        repeat (4) step(1, 1);
        lit("pre_clear_t4", o_alu_op, 5'b01011);
        i_clear = 1'b1;
        #1 lit("clear_outs", act, 70'h0);
        step(1, 1);
        i_clear = 1'b0;
        step(1, 1);
        lit("clear_restart_t0", o_pcout, 1);

        // Run dropped in T4: instruction still completes, then idle
        repeat (4) step(1, 1);
        step(0, 1);
        lit("runstop_done", o_done, 1);
        step(0, 1);
        lit("runstop_count", o_instr_count, 16'd1);
        step(0, 1);
        lit("runstop_idle", act, 70'h1);

        // Counter wrap
        force dut.r_instr_count = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step(0, 0);
        release dut.r_instr_count;
        step(0, 0);
        lit("wrap_pre", o_instr_count, 16'hFFFF);
        repeat (6) step(1, 1);
        step(0, 1);
        lit("wrap_count", o_instr_count, 16'h0000);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            next_ir = {5'($urandom_range(0, 20)), 27'($urandom)};
            if ($urandom_range(0, 199) == 0) begin
                i_clear = 1'b1;
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                i_clear = 1'b0;
            end else begin
                step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
